// File: rtl/key_filter_multi_if.sv
`default_nettype none
// ============================================================================
//  Module   : key_filter_multi_if
//  Brief    : Bundle of raw key pins and debounced event outputs for the
//             multi-channel key filter.
//  Revision : 1.0 - initial release
// ============================================================================
interface key_filter_multi_if #(
    parameter int N_KEYS = 4
);
    logic [N_KEYS-1:0] key_in;
    logic [N_KEYS-1:0] key_level;
    logic [N_KEYS-1:0] key_press;
    logic [N_KEYS-1:0] key_release;
    logic [N_KEYS-1:0] key_long;

    // Drives the raw pins and consumes the filtered events
    modport master (
        output key_in,
        input  key_level,
        input  key_press,
        input  key_release,
        input  key_long
    );

    // The filter itself
    modport slave (
        input  key_in,
        output key_level,
        output key_press,
        output key_release,
        output key_long
    );
endinterface
`default_nettype wire

// File: rtl/key_filter_multi.sv
`default_nettype none
// ============================================================================
//  Module   : key_filter_multi
//  Brief    : N-channel push-button debouncer. Each channel synchronises its
//             raw pin, debounces it with a 4-state FSM and emits a stable
//             level plus one-cycle press / release / long-press strobes.
//  Revision : 1.0 - initial release
// ============================================================================
module key_filter_multi #(
    parameter int N_KEYS     = 4,
    parameter int T_DEBOUNCE = 500_000,
    parameter int T_LONG     = 50_000_000,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    key_filter_multi_if.slave  bus
);

    localparam int c_CNT_W  = (T_DEBOUNCE > 1) ? $clog2(T_DEBOUNCE) : 1;
    localparam int c_HCNT_W = (T_LONG > 0) ? $clog2(T_LONG + 1) : 1;

    localparam logic [1:0] c_IDLE      = 2'd0;
    localparam logic [1:0] c_ON_SHAKE  = 2'd1;
    localparam logic [1:0] c_HELD      = 2'd2;
    localparam logic [1:0] c_OFF_SHAKE = 2'd3;

    // Synchroniser reset value: the pin level of a key that is not pressed
    localparam logic                c_RELEASED = ACTIVE_LOW;
    localparam logic [c_CNT_W-1:0]  c_DEB_LAST = c_CNT_W'(T_DEBOUNCE - 1);
    localparam logic [c_CNT_W-1:0]  c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_HCNT_W-1:0] c_LONG     = c_HCNT_W'(T_LONG);
    localparam logic [c_HCNT_W-1:0] c_HCNT_ONE = c_HCNT_W'(1);
    localparam bit                  c_LONG_EN  = (T_LONG != 0);

    genvar gi;
    generate
        for (gi = 0; gi < N_KEYS; gi++) begin : g_ch
            logic                r_sync1;
            logic                r_sync2;
            logic [1:0]          r_state;
            logic [c_CNT_W-1:0]  r_cnt;
            logic [c_HCNT_W-1:0] r_hcnt;
            logic                r_level;
            logic                r_press;
            logic                r_release;
            logic                r_long;

            logic                w_p;
            logic [1:0]          w_state_nx;
            logic [c_CNT_W-1:0]  w_cnt_nx;
            logic [c_HCNT_W-1:0] w_hcnt_nx;
            logic [c_HCNT_W-1:0] w_hinc;
            logic                w_level_nx;
            logic                w_press_nx;
            logic                w_release_nx;
            logic                w_long_nx;

            // Normalised "pressed" view of the synchronised pin
            assign w_p    = r_sync2 ^ c_RELEASED;
            assign w_hinc = r_hcnt + c_HCNT_ONE;

            // Two-flop synchroniser for the asynchronous key pin
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_sync1 <= c_RELEASED;
                    r_sync2 <= c_RELEASED;
                end else begin
                    r_sync1 <= bus.key_in[gi];
                    r_sync2 <= r_sync1;
                end
            end

            // Debounce FSM next state, counters and the strobe for the transition taken
            always_comb begin
                w_state_nx   = r_state;
                w_cnt_nx     = r_cnt;
                w_hcnt_nx    = r_hcnt;
                w_press_nx   = 1'b0;
                w_release_nx = 1'b0;
                w_long_nx    = 1'b0;
                case (r_state)
                    c_IDLE: begin
                        w_cnt_nx  = '0;
                        w_hcnt_nx = '0;
                        if (w_p) begin
                            w_state_nx = c_ON_SHAKE;
                        end
                    end
                    c_ON_SHAKE: begin
                        if (!w_p) begin
                            w_state_nx = c_IDLE;
                            w_cnt_nx   = '0;
                        end else if (r_cnt == c_DEB_LAST) begin
                            w_state_nx = c_HELD;
                            w_cnt_nx   = '0;
                            w_hcnt_nx  = '0;
                            w_press_nx = 1'b1;
                        end else begin
                            w_cnt_nx = r_cnt + c_CNT_ONE;
                        end
                    end
                    c_HELD: begin
                        if (!w_p) begin
                            w_state_nx = c_OFF_SHAKE;
                            w_cnt_nx   = '0;
                        end else if (c_LONG_EN && (r_hcnt < c_LONG)) begin
                            // Saturating at T_LONG makes the long strobe one-shot
                            w_hcnt_nx = w_hinc;
                            w_long_nx = (w_hinc == c_LONG);
                        end
                    end
                    c_OFF_SHAKE: begin
                        if (w_p) begin
                            // Release glitch: hold timing continues where it left off
                            w_state_nx = c_HELD;
                            w_cnt_nx   = '0;
                        end else if (r_cnt == c_DEB_LAST) begin
                            w_state_nx   = c_IDLE;
                            w_cnt_nx     = '0;
                            w_release_nx = 1'b1;
                        end else begin
                            w_cnt_nx = r_cnt + c_CNT_ONE;
                        end
                    end
                    default: begin
                        w_state_nx = c_IDLE;
                        w_cnt_nx   = '0;
                        w_hcnt_nx  = '0;
                    end
                endcase
                w_level_nx = (w_state_nx == c_HELD) || (w_state_nx == c_OFF_SHAKE);
            end

            // State, counters and registered outputs
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_state   <= c_IDLE;
                    r_cnt     <= '0;
                    r_hcnt    <= '0;
                    r_level   <= 1'b0;
                    r_press   <= 1'b0;
                    r_release <= 1'b0;
                    r_long    <= 1'b0;
                end else begin
                    r_state   <= w_state_nx;
                    r_cnt     <= w_cnt_nx;
                    r_hcnt    <= w_hcnt_nx;
                    r_level   <= w_level_nx;
                    r_press   <= w_press_nx;
                    r_release <= w_release_nx;
                    r_long    <= w_long_nx;
                end
            end

            assign bus.key_level[gi]   = r_level;
            assign bus.key_press[gi]   = r_press;
            assign bus.key_release[gi] = r_release;
            assign bus.key_long[gi]    = r_long;
        end
    endgenerate

endmodule
`default_nettype wire
